// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
//   muldiv_op_e    : funct3 encodings of the eight M-extension operations
//   muldiv_state_e : control FSM states
//   min_value()    : most negative two's-complement value for a given XLEN
package muldiv_pkg;

  // Widest XLEN that min_value() can describe.
  localparam int unsigned MAX_XLEN = 128;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } muldiv_state_e;

  // Only bit xlen-1 is set; callers truncate the result to their own XLEN.
  function automatic logic [MAX_XLEN-1:0] min_value(input int unsigned xlen);
    return MAX_XLEN'(1) << (xlen - 1);
  endfunction

endpackage

// File: rtl/muldiv_sign_prep.sv
// Operand conditioning for the multiply/divide unit (combinational).
// Ports:
//   op          : operation being presented
//   a, b        : raw rs1/rs2 operands
//   a_mag_c     : |a| when a is treated as signed, otherwise a
//   b_mag_c     : |b| when b is treated as signed, otherwise b
//   neg_res_c   : product/quotient must be negated (sign(a) xor sign(b))
//   neg_rem_c   : remainder must be negated (sign of the dividend)
module muldiv_sign_prep
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  muldiv_op_e        op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   a_mag_c,
  output logic [XLEN-1:0]   b_mag_c,
  output logic              neg_res_c,
  output logic              neg_rem_c
);

  logic a_signed;
  logic b_signed;
  logic a_neg;
  logic b_neg;

  // MULHSU reads a as signed but b as unsigned; MUL needs no sign handling
  // since the low half of the product is identical either way.
  always_comb begin
    a_signed  = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed  = op inside {OP_MULH, OP_DIV, OP_REM};
    a_neg     = a_signed & a[XLEN-1];
    b_neg     = b_signed & b[XLEN-1];
    // -MIN wraps to MIN, which read unsigned is the correct magnitude.
    a_mag_c   = a_neg ? -a : a;
    b_mag_c   = b_neg ? -b : b;
    neg_res_c = a_neg ^ b_neg;
    neg_rem_c = a_neg;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit with valid/ready handshakes.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   flush                : abort any in-flight operation, return to IDLE
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   op, a, b             : funct3 and rs1/rs2 operands
//   out_valid / out_ready: result handshake (result held until accepted)
//   result               : operation result
//   zero, negative       : status flags registered with result
//   busy                 : unit is not IDLE
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CW   = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic             negative,
  output logic             busy
);

  localparam int unsigned    PW       = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_VAL  = XLEN'(min_value(XLEN));
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN - 1);

  muldiv_state_e   state, state_next;
  muldiv_op_e      op_in;
  muldiv_op_e      op_q, op_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [XLEN-1:0] bop_q, bop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_d;

  logic [XLEN-1:0] a_mag_c;
  logic [XLEN-1:0] b_mag_c;
  logic            neg_res_c;
  logic            neg_rem_c;

  logic            special_c;
  logic [XLEN-1:0] special_res_c;
  logic [XLEN:0]   mul_add_c;
  logic [XLEN:0]   div_trial_c;
  logic [PW-1:0]   step_c;
  logic [PW-1:0]   prod_fix_c;
  logic [XLEN-1:0] fix_res_c;

  assign op_in = muldiv_op_e'(op);

  muldiv_sign_prep #(.XLEN(XLEN)) u_sign_prep (
    .op        (op_in),
    .a         (a),
    .b         (b),
    .a_mag_c   (a_mag_c),
    .b_mag_c   (b_mag_c),
    .neg_res_c (neg_res_c),
    .neg_rem_c (neg_rem_c)
  );

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  always_comb begin
    logic b_zero;
    logic ovf;
    b_zero        = (b == '0);
    ovf           = (op_in inside {OP_DIV, OP_REM}) && (a == MIN_VAL) && (b == '1);
    special_c     = op_in[2] && (b_zero || ovf);
    special_res_c = '0;
    if (b_zero) begin
      special_res_c = op_in[1] ? a : '1;
    end else if (ovf) begin
      special_res_c = op_in[1] ? '0 : MIN_VAL;
    end
  end

  // One radix-2 step. prod_q holds {hi, lo}: for multiply {partial, multiplier},
  // for divide {remainder, dividend shifting out / quotient shifting in}.
  always_comb begin
    mul_add_c   = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, bop_q} : '0);
    div_trial_c = prod_q[PW-1:XLEN-1] - {1'b0, bop_q};
    if (op_q[2]) begin
      step_c = div_trial_c[XLEN] ? {prod_q[PW-2:0], 1'b0}
                                 : {div_trial_c[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    end else begin
      step_c = {mul_add_c, prod_q[XLEN-1:1]};
    end
  end

  // Sign correction and result selection.
  always_comb begin
    prod_fix_c = neg_res_q ? -prod_q : prod_q;
    unique case (op_q)
      OP_MUL:                       fix_res_c = prod_fix_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res_c = prod_fix_c[PW-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res_c = neg_res_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
      default:                      fix_res_c = neg_rem_q ? -prod_q[PW-1:XLEN] : prod_q[PW-1:XLEN];
    endcase
  end

  // Next-state and datapath next values.
  always_comb begin
    state_next = state;
    op_d       = op_q;
    prod_d     = prod_q;
    bop_d      = bop_q;
    cnt_d      = cnt_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result;
    if (flush) begin
      state_next = ST_IDLE;
      cnt_d      = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_d      = op_in;
            prod_d    = {{XLEN{1'b0}}, a_mag_c};
            bop_d     = b_mag_c;
            neg_res_d = neg_res_c;
            neg_rem_d = neg_rem_c;
            cnt_d     = CNT_LOAD;
            if (special_c) begin
              result_d   = special_res_c;
              state_next = ST_DONE;
            end else begin
              state_next = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          prod_d = step_c;
          if (cnt_q == '0) begin
            state_next = ST_FIX;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_FIX: begin
          result_d   = fix_res_c;
          state_next = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers; handshake outputs follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_MUL;
      prod_q    <= '0;
      bop_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      negative  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      op_q      <= op_d;
      prod_q    <= prod_d;
      bop_q     <= bop_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result    <= result_d;
      zero      <= (result_d == '0);
      negative  <= result_d[XLEN-1];
      out_valid <= (state_next == ST_DONE);
      in_ready  <= (state_next == ST_IDLE);
      busy      <= (state_next != ST_IDLE);
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit for the EX stage. It runs alongside the single-cycle ALU and handles the eight M-extension operations. It is parametrised in XLEN and uses a valid/ready handshake on both input and output. A pipeline flush aborts any in-flight operation. The result port carries the same zero/negative status flags as the ALU.

Parameters:
XLEN, 32, operand/result width; any even value >= 8
CW, $clog2(XLEN), iteration counter width (derived)

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  abort current operation; wins over all other inputs
in_valid  in  1  operands and op are valid
in_ready  out  1  unit can accept (high only in IDLE)
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  in  XLEN  rs1 operand
b  in  XLEN  rs2 operand
out_valid  out  1  result valid; held until out_ready
out_ready  in  1  consumer accepts result
result  out  XLEN  operation result
zero  out  1  result == 0
negative  out  1  result[XLEN-1]
busy  out  1  state != IDLE

Behaviour:
- Reset and timing: clk is the single clock; rst is synchronous and active-high. On rst, state=IDLE, out_valid=0, result=0, zero=1, negative=0, busy=0, and all internal registers are cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch op, the operand magnitudes (absolute value for signed operands; MULHSU treats b as unsigned) and the result-sign flags.
  - Load the counter with XLEN-1, then go to CALC.
  - Special cases go directly to DONE with the final result already loaded:
    - DIV/DIVU with b==0: quotient = all ones.
    - REM/REMU with b==0: remainder = a.
    - DIV with a==MIN and b==-1: quotient = MIN.
    - REM with a==MIN and b==-1: remainder = 0.
- CALC:
  - One radix-2 step per cycle for XLEN cycles (counter decrements; leave CALC when counter==0).
  - Multiply: shift-add into a 2*XLEN product register.
  - Divide: restoring shift-subtract producing quotient and remainder registers.
- FIX (1 cycle):
  - Apply sign correction (two's-complement negate of the magnitude result when the sign flag is set).
  - Select the result: MUL takes the low XLEN bits, MULH/MULHSU/MULHU take the high XLEN bits, DIV/DIVU take the quotient, REM/REMU take the remainder.
  - Go to DONE.
- DONE:
  - out_valid=1; result, zero and negative are stable.
  - On out_ready, go to IDLE with out_valid=0 in the next cycle.
  - result holds its last value in IDLE.
- Latency, with accept in cycle 0:
  - Normal ops: out_valid is high from cycle XLEN+2 (cycle 34 for XLEN=32).
  - Special cases: out_valid is high from cycle 1.
- Back-to-back: a new input can be accepted no earlier than the cycle after the DONE handshake; in_ready is 0 in DONE.
- Signed arithmetic:
  - The remainder takes the sign of the dividend.
  - The quotient sign is sign(a) XOR sign(b).
  - All intermediate arithmetic is unsigned at XLEN+1 bits, so no overflow is lost.
- Flush:
  - From any state, the next state is IDLE, out_valid=0 and the counter is cleared.
  - A flush in the same cycle as in_valid in IDLE does not accept the operation.
  - rst has priority over flush.
- zero and negative are registered together with result, so they are never stale relative to it.

Decomposition:
- Package muldiv_pkg:
  - enum muldiv_op_e (the 8 funct3 codes).
  - enum muldiv_state_e (IDLE/CALC/FIX/DONE).
  - Helper constant for the XLEN-dependent MIN value.
- One sub-module: muldiv_sign_prep. It is combinational and produces the operand magnitudes and sign flags from op, a and b. It is shared by the IDLE latch and the special-case detection.

Test Plan:
- MUL, a=7, b=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB, negative=1, out_valid in cycle 34, in_ready=0 throughout.
- MULH, a=0x80000000, b=0x80000000 -> 0x40000000. MULHU with the same operands -> 0x40000000. MULHSU, a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV, a=-7, b=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU, a=100, b=7 -> 14. REMU with the same operands -> 2.
- DIVU, b=0, a=5 -> 0xFFFFFFFF in cycle 1. REM, b=0, a=5 -> 5. DIV, a=0x80000000, b=-1 -> 0x80000000. REM with the same operands -> 0 with zero=1.
- Start DIV, assert flush in cycle 10 -> IDLE and in_ready=1 in cycle 11, out_valid never rises. The next MUL 3*4 returns 12 correctly.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and result stay stable and in_ready stays 0. Assert rst mid-CALC -> all outputs at their reset values in the next cycle.
